// File: rtl/glycemic_pkg.sv
// Shared types and sizing helpers for the glycemic index monitor.
package glycemic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    EMIT
  } state_t;

  localparam int DEF_LOW_TH     = 2;
  localparam int DEF_HIGH_TH    = 12;
  localparam int DEF_ALARM_HOLD = 3;

  function automatic int sum_width(
    input int sample_w,
    input int log_depth
  );
    return sample_w + log_depth;
  endfunction

  function automatic int shift_amount(
    input int sample_w,
    input int log_depth,
    input int index_w
  );
    return log_depth + sample_w - index_w;
  endfunction

endpackage

// File: rtl/glycemic_alarm_filter.sv
// Per-channel run counters and sticky high/low alarms.
// Only built when GLYCEMIC_ALARM_EN is defined.
`ifdef GLYCEMIC_ALARM_EN
module glycemic_alarm_filter
  import glycemic_pkg::*;
#(
  parameter int INDEX_W    = 4,
  parameter int LOW_TH     = DEF_LOW_TH,
  parameter int HIGH_TH    = DEF_HIGH_TH,
  parameter int ALARM_HOLD = DEF_ALARM_HOLD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [INDEX_W-1:0] index,
  output logic               alarm_high,
  output logic               alarm_low
);

  localparam int CNT_W = $clog2(ALARM_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD = CNT_W'(ALARM_HOLD);
  localparam logic [CNT_W-1:0] STEP = CNT_W'(1);
  localparam logic [INDEX_W-1:0] HI = INDEX_W'(HIGH_TH);
  localparam logic [INDEX_W-1:0] LO = INDEX_W'(LOW_TH);

  logic [CNT_W-1:0] hi_q;
  logic [CNT_W-1:0] lo_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (en) begin
      if (index >= HI) begin
        if (hi_q != HOLD) hi_q <= hi_q + STEP;
      end else begin
        hi_q <= '0;
      end
      if (index <= LO) begin
        if (lo_q != HOLD) lo_q <= lo_q + STEP;
      end else begin
        lo_q <= '0;
      end
    end
  end

  // Counters saturate at HOLD, so the flag is sticky until a clearing index.
  assign alarm_high = (hi_q == HOLD);
  assign alarm_low  = (lo_q == HOLD);

endmodule
`endif

// File: rtl/glycemic_index_monitor.sv
// Multi-channel moving-average glycemic index monitor.
// Alarm filters are built only when GLYCEMIC_ALARM_EN is defined.
module glycemic_index_monitor
  import glycemic_pkg::*;
#(
  parameter int SAMPLE_W   = 8,
  parameter int INDEX_W    = 4,
  parameter int CHANNELS   = 4,
  parameter int LOG_DEPTH  = 2,
  parameter int LOW_TH     = DEF_LOW_TH,
  parameter int HIGH_TH    = DEF_HIGH_TH,
  parameter int ALARM_HOLD = DEF_ALARM_HOLD
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        sampleValid,
  output logic                        sampleReady,
  input  logic [$clog2(CHANNELS)-1:0] sampleChannel,
  input  logic [SAMPLE_W-1:0]         bloodSensor,
  output logic                        indexValid,
  output logic [$clog2(CHANNELS)-1:0] indexChannel,
  output logic [INDEX_W-1:0]          glycemicIndex,
  output logic [CHANNELS-1:0]         alarmHigh,
  output logic [CHANNELS-1:0]         alarmLow
);

  localparam int CH_W  = $clog2(CHANNELS);
  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam int SUM_W = sum_width(SAMPLE_W, LOG_DEPTH);
  localparam int SHIFT = shift_amount(SAMPLE_W, LOG_DEPTH, INDEX_W);
  localparam logic [LOG_DEPTH:0]   FULL  = (LOG_DEPTH + 1)'(DEPTH);
  localparam logic [LOG_DEPTH:0]   CSTEP = (LOG_DEPTH + 1)'(1);
  localparam logic [LOG_DEPTH-1:0] PSTEP = LOG_DEPTH'(1);

  if (INDEX_W > SAMPLE_W) begin : g_bad_width
    $error("INDEX_W must not exceed SAMPLE_W");
  end
  if (CHANNELS < 2) begin : g_bad_channels
    $error("CHANNELS must be at least 2");
  end
  if (ALARM_HOLD < 1) begin : g_bad_hold
    $error("ALARM_HOLD must be at least 1");
  end
  if (LOW_TH >= HIGH_TH) begin : g_bad_th
    $error("LOW_TH must be below HIGH_TH");
  end

  state_t state_q;
  state_t state_d;

  logic [CH_W-1:0]      ch_q;
  logic [SAMPLE_W-1:0]  smp_q;
  logic [SAMPLE_W-1:0]  ring_q [CHANNELS][DEPTH];
  logic [LOG_DEPTH-1:0] ptr_q  [CHANNELS];
  logic [LOG_DEPTH:0]   cnt_q  [CHANNELS];
  logic [SUM_W-1:0]     sum_q  [CHANNELS];

  logic                 accept;
  logic                 upd;
  logic                 fire;
  logic [SAMPLE_W-1:0]  oldest;
  logic [SUM_W-1:0]     sum_new;
  logic [LOG_DEPTH:0]   cnt_new;
  logic [INDEX_W-1:0]   index_new;

  assign sampleReady = (state_q == IDLE) && !reset;
  assign accept      = sampleValid && sampleReady;
  assign upd         = (state_q == UPDATE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (sampleValid) state_d = UPDATE;
      UPDATE:  state_d = EMIT;
      EMIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // While a channel is filling, the slot being overwritten holds no sample yet.
  always_comb begin
    oldest    = '0;
    if (cnt_q[ch_q] == FULL) oldest = ring_q[ch_q][ptr_q[ch_q]];
    sum_new   = sum_q[ch_q] - SUM_W'(oldest) + SUM_W'(smp_q);
    cnt_new   = (cnt_q[ch_q] == FULL) ? FULL : cnt_q[ch_q] + CSTEP;
    index_new = INDEX_W'(sum_new >> SHIFT);
    fire      = upd && (cnt_new == FULL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      ch_q          <= '0;
      smp_q         <= '0;
      indexValid    <= 1'b0;
      indexChannel  <= '0;
      glycemicIndex <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        ptr_q[c] <= '0;
        cnt_q[c] <= '0;
        sum_q[c] <= '0;
        for (int d = 0; d < DEPTH; d++) ring_q[c][d] <= '0;
      end
    end else begin
      state_q    <= state_d;
      indexValid <= fire;
      if (accept) begin
        ch_q  <= sampleChannel;
        smp_q <= bloodSensor;
      end
      if (upd) begin
        ring_q[ch_q][ptr_q[ch_q]] <= smp_q;
        ptr_q[ch_q] <= ptr_q[ch_q] + PSTEP;
        cnt_q[ch_q] <= cnt_new;
        sum_q[ch_q] <= sum_new;
      end
      if (fire) begin
        indexChannel  <= ch_q;
        glycemicIndex <= index_new;
      end
    end
  end

`ifdef GLYCEMIC_ALARM_EN
  for (genvar c = 0; c < CHANNELS; c++) begin : g_alarm
    glycemic_alarm_filter #(
      .INDEX_W   (INDEX_W),
      .LOW_TH    (LOW_TH),
      .HIGH_TH   (HIGH_TH),
      .ALARM_HOLD(ALARM_HOLD)
    ) u_filter (
      .clk       (clk),
      .reset     (reset),
      .en        (fire && (ch_q == CH_W'(c))),
      .index     (index_new),
      .alarm_high(alarmHigh[c]),
      .alarm_low (alarmLow[c])
    );
  end
`else
  assign alarmHigh = '0;
  assign alarmLow  = '0;
`endif

endmodule

// File: tb/tb_glycemic_index_monitor.sv
// Directed bench for glycemic_index_monitor with a reference scoreboard.
module tb_glycemic_index_monitor;

`ifdef GLYCEMIC_ALARM_EN
  localparam bit ALARM_ON = 1'b1;
`else
  localparam bit ALARM_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       sampleValid;
  logic       sampleReady;
  logic [1:0] sampleChannel;
  logic [7:0] bloodSensor;
  logic       indexValid;
  logic [1:0] indexChannel;
  logic [3:0] glycemicIndex;
  logic [3:0] alarmHigh;
  logic [3:0] alarmLow;

  always #5 clk = ~clk;

  glycemic_index_monitor dut (
    .clk          (clk),
    .reset        (reset),
    .sampleValid  (sampleValid),
    .sampleReady  (sampleReady),
    .sampleChannel(sampleChannel),
    .bloodSensor  (bloodSensor),
    .indexValid   (indexValid),
    .indexChannel (indexChannel),
    .glycemicIndex(glycemicIndex),
    .alarmHigh    (alarmHigh),
    .alarmLow     (alarmLow)
  );

  typedef struct {
    int         ch;
    int         idx;
    logic [3:0] ah;
    logic [3:0] al;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int         hist [4][4];
  int         cnt  [4];
  int         wp   [4];
  int         hrun [4];
  int         lrun [4];
  logic [3:0] m_ah;
  logic [3:0] m_al;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_checks++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < 4; c++) begin
      cnt[c]  = 0;
      wp[c]   = 0;
      hrun[c] = 0;
      lrun[c] = 0;
      for (int k = 0; k < 4; k++) hist[c][k] = 0;
    end
    m_ah = '0;
    m_al = '0;
  endfunction

  function automatic bit model_push(input int ch, input int val);
    int   s;
    int   idx;
    exp_t e;
    hist[ch][wp[ch]] = val;
    wp[ch] = (wp[ch] + 1) % 4;
    if (cnt[ch] < 4) cnt[ch]++;
    if (cnt[ch] < 4) return 1'b0;
    s = 0;
    for (int k = 0; k < 4; k++) s += hist[ch][k];
    idx = s >> 6;
    hrun[ch] = (idx >= 12) ? ((hrun[ch] < 3) ? hrun[ch] + 1 : 3) : 0;
    lrun[ch] = (idx <= 2) ? ((lrun[ch] < 3) ? lrun[ch] + 1 : 3) : 0;
    if (ALARM_ON) begin
      m_ah[ch] = (hrun[ch] == 3);
      m_al[ch] = (lrun[ch] == 3);
    end
    e.ch  = ch;
    e.idx = idx;
    e.ah  = m_ah;
    e.al  = m_al;
    exp_q.push_back(e);
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (indexValid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_emit", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_channel", indexChannel, e.ch);
        chk("sb_index", glycemicIndex, e.idx);
        chk("sb_alarm_high", alarmHigh, e.ah);
        chk("sb_alarm_low", alarmLow, e.al);
      end
    end
  end

  task automatic send(input int ch, input int val);
    int guard;
    bit fire;
    guard = 0;
    @(negedge clk);
    sampleValid   = 1'b1;
    sampleChannel = 2'(ch);
    bloodSensor   = 8'(val);
    while (sampleReady !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("accept_wait", guard < 20, 1);
    fire = model_push(ch, val);
    @(negedge clk);
    sampleValid = 1'b0;
    chk("no_emit_t1", indexValid, 0);
    @(negedge clk);
    chk("emit_t2", indexValid, fire);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int last;
    int nacc;
    int guard;
    model_reset();
    reset         = 1'b1;
    sampleValid   = 1'b0;
    sampleChannel = '0;
    bloodSensor   = '0;

    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", sampleReady, 0);
      chk("rst_valid", indexValid, 0);
      chk("rst_index", {indexChannel, glycemicIndex}, 0);
      chk("rst_alarms", {alarmHigh, alarmLow}, 0);
    end
    reset = 1'b0;
    #1;
    chk("ready_after_reset", sampleReady, 1);

    send(0, 'h11);
    send(0, 'h91);
    send(0, 'h17);
    send(0, 'h11);
    chk("ch0_first_index", glycemicIndex, 3);
    chk("ch0_first_channel", indexChannel, 0);
    send(0, 'hFF);
    chk("ch0_second_index", glycemicIndex, 6);

    for (int i = 0; i < 6; i++) begin
      send(1, 'hF0);
      if (i >= 3) chk("ch1_high_index", glycemicIndex, 15);
      send(0, 'h80);
    end
    send(1, 'hF0);
    chk("ch1_alarm_set", alarmHigh[1], ALARM_ON);
    chk("ch0_alarms_quiet", {alarmHigh[0], alarmLow[0]}, 0);
    send(1, 'h00);
    chk("ch1_drop_index", glycemicIndex, 11);
    chk("ch1_alarm_clear", alarmHigh[1], 0);

    for (int i = 0; i < 6; i++) send(2, 'h00);
    chk("ch2_low_index", glycemicIndex, 0);
    chk("ch2_alarm_low", alarmLow[2], ALARM_ON);

    @(negedge clk);
    sampleValid   = 1'b1;
    sampleChannel = 2'd3;
    bloodSensor   = 8'hC0;
    last = -1;
    nacc = 0;
    for (int i = 0; i < 12; i++) begin
      if (sampleReady === 1'b1) begin
        void'(model_push(3, 'hC0));
        if (last >= 0) chk("accept_spacing", i - last, 3);
        last = i;
        nacc++;
      end
      @(negedge clk);
    end
    sampleValid = 1'b0;
    chk("accept_count", nacc, 4);
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    sampleValid   = 1'b1;
    sampleChannel = 2'd0;
    bloodSensor   = 8'h55;
    guard = 0;
    while (sampleReady !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("mid_accept_wait", guard < 20, 1);
    @(negedge clk);
    sampleValid = 1'b0;
    reset       = 1'b1;
    @(negedge clk);
    chk("mid_rst_no_emit", indexValid, 0);
    chk("mid_rst_ready", sampleReady, 0);
    @(negedge clk);
    chk("mid_rst_no_emit2", indexValid, 0);
    chk("mid_rst_alarms", {alarmHigh, alarmLow}, 0);
    reset = 1'b0;
    model_reset();

    send(1, 'h40);
    send(0, 'h40);
    send(0, 'h40);
    send(0, 'h40);
    send(0, 'h40);
    chk("rewarm_index", glycemicIndex, 4);
    chk("rewarm_channel", indexChannel, 0);

    repeat (4) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
